// File: rtl/hazard_ctrl_seq.sv
// Sequential hazard controller for the 5-stage RV32I pipeline: stage stall/flush,
// EX forwarding selects, multi-cycle load-use bubbles and a stall-cycle counter.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RUN     | normal flow; a load-use hit inserts the first bubble
// S_LU_WAIT | further load-use bubbles while the slow load completes
module hazard_ctrl_seq #(
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              clk_i,
    input  logic              CpuRst_i,
    input  logic              ICacheMiss_i,
    input  logic              DCacheMiss_i,
    input  logic              BranchE_i,
    input  logic              JalrE_i,
    input  logic              JalD_i,
    input  logic [REG_AW-1:0] Rs1D_i,
    input  logic [REG_AW-1:0] Rs2D_i,
    input  logic [REG_AW-1:0] Rs1E_i,
    input  logic [REG_AW-1:0] Rs2E_i,
    input  logic [REG_AW-1:0] RdE_i,
    input  logic [REG_AW-1:0] RdM_i,
    input  logic [REG_AW-1:0] RdW_i,
    input  logic [1:0]        RegReadD_i,
    input  logic [1:0]        RegReadE_i,
    input  logic              MemToRegE_i,
    input  logic [2:0]        RegWriteM_i,
    input  logic [2:0]        RegWriteW_i,
    output logic              StallF_o,
    output logic              FlushF_o,
    output logic              StallD_o,
    output logic              FlushD_o,
    output logic              StallE_o,
    output logic              FlushE_o,
    output logic              StallM_o,
    output logic              FlushM_o,
    output logic              StallW_o,
    output logic              FlushW_o,
    output logic [1:0]        Forward1E_o,
    output logic [1:0]        Forward2E_o,
    output logic [CNT_W-1:0]  StallCount_o
);

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_LU_WAIT = 1'b1;

    localparam int             LCW     = $clog2(LOAD_LAT + 1);
    localparam logic [LCW-1:0] LU_LOAD = LCW'(LOAD_LAT - 1);
    localparam logic [LCW-1:0] LU_LAST = LCW'(1);
    localparam bit             MULTI   = (LOAD_LAT > 1);

    logic [0:0]       state_q, state_d;
    logic [LCW-1:0]   lu_cnt_q, lu_cnt_d;
    logic             redir_pend_q, redir_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic lu_hit, in_wait, lu_act, redir;
    logic m_hit1, w_hit1, m_hit2, w_hit2;

    assign lu_hit  = MemToRegE_i && (RdE_i != '0) &&
                     ((RegReadD_i[1] && (RdE_i == Rs1D_i)) ||
                      (RegReadD_i[0] && (RdE_i == Rs2D_i)));
    assign in_wait = (state_q == S_LU_WAIT);
    assign lu_act  = lu_hit || in_wait;
    assign redir   = BranchE_i || JalrE_i;

    assign m_hit1 = (RdM_i != '0) && (|RegWriteM_i) && RegReadE_i[1] && (RdM_i == Rs1E_i);
    assign w_hit1 = (RdW_i != '0) && (|RegWriteW_i) && RegReadE_i[1] && (RdW_i == Rs1E_i);
    assign m_hit2 = (RdM_i != '0) && (|RegWriteM_i) && RegReadE_i[0] && (RdM_i == Rs2E_i);
    assign w_hit2 = (RdW_i != '0) && (|RegWriteW_i) && RegReadE_i[0] && (RdW_i == Rs2E_i);

    always_comb begin
        StallF_o    = 1'b0;
        FlushF_o    = 1'b0;
        StallD_o    = 1'b0;
        FlushD_o    = 1'b0;
        StallE_o    = 1'b0;
        FlushE_o    = 1'b0;
        StallM_o    = 1'b0;
        FlushM_o    = 1'b0;
        StallW_o    = 1'b0;
        FlushW_o    = 1'b0;
        Forward1E_o = {m_hit1, w_hit1 && !m_hit1};
        Forward2E_o = {m_hit2, w_hit2 && !m_hit2};
        if (CpuRst_i) begin
            FlushF_o    = 1'b1;
            FlushD_o    = 1'b1;
            FlushE_o    = 1'b1;
            FlushM_o    = 1'b1;
            FlushW_o    = 1'b1;
            Forward1E_o = 2'b00;
            Forward2E_o = 2'b00;
        end else if (DCacheMiss_i) begin
            // Whole pipe freezes; a branch held in EX re-asserts after the miss.
            StallF_o = 1'b1;
            StallD_o = 1'b1;
            StallE_o = 1'b1;
            StallM_o = 1'b1;
            StallW_o = 1'b1;
        end else begin
            StallF_o = !redir && (ICacheMiss_i || lu_act);
            StallD_o = !redir && lu_act;
            FlushD_o = redir || (JalD_i && !lu_act) || (ICacheMiss_i && !lu_act) ||
                       (redir_pend_q && !ICacheMiss_i);
            FlushE_o = redir || lu_act;
        end
    end

    always_comb begin
        state_d      = state_q;
        lu_cnt_d     = lu_cnt_q;
        redir_pend_d = redir_pend_q;
        if (!DCacheMiss_i) begin
            if (redir) begin
                state_d  = S_RUN;
                lu_cnt_d = '0;
            end else if (in_wait) begin
                lu_cnt_d = lu_cnt_q - 1'b1;
                if (lu_cnt_q == LU_LAST) state_d = S_RUN;
            end else if (lu_hit && MULTI) begin
                state_d  = S_LU_WAIT;
                lu_cnt_d = LU_LOAD;
            end
            // Remember a redirect whose wrong-path fetch is still outstanding.
            if (redir && ICacheMiss_i)  redir_pend_d = 1'b1;
            else if (!ICacheMiss_i)     redir_pend_d = 1'b0;
        end
        cnt_d = (StallF_o && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or posedge CpuRst_i) begin
        if (CpuRst_i) begin
            state_q      <= S_RUN;
            lu_cnt_q     <= '0;
            redir_pend_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            lu_cnt_q     <= lu_cnt_d;
            redir_pend_q <= redir_pend_d;
            cnt_q        <= cnt_d;
        end
    end

    assign StallCount_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_seq.sv
// Bench for hazard_ctrl_seq: a LOAD_LAT=3/CNT_W=3 instance and a LOAD_LAT=1 instance
// share stimulus and are checked against a cycle-level behavioural model.
module tb_hazard_ctrl_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, imiss, dmiss, br, jalr, jal, ld;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rrd, rre;
    logic [2:0] rwm, rww;

    logic [1:0] stF, flF, stD, flD, stE, flE, stM, flM, stW, flW;
    logic [1:0] f1 [2];
    logic [1:0] f2 [2];
    logic [2:0]  cnt_a;
    logic [31:0] cnt_b;

    int tests = 0;
    int fails = 0;

    int     lat   [2] = '{3, 1};
    longint cmax  [2] = '{7, 64'hFFFF_FFFF};
    int     rem   [2];
    bit     pend  [2];
    longint cnt   [2];
    int     std_seen [2];

    hazard_ctrl_seq #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(3)) u_a (
        .clk_i(clk), .CpuRst_i(rst), .ICacheMiss_i(imiss), .DCacheMiss_i(dmiss),
        .BranchE_i(br), .JalrE_i(jalr), .JalD_i(jal),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .RegReadD_i(rrd), .RegReadE_i(rre), .MemToRegE_i(ld),
        .RegWriteM_i(rwm), .RegWriteW_i(rww),
        .StallF_o(stF[0]), .FlushF_o(flF[0]), .StallD_o(stD[0]), .FlushD_o(flD[0]),
        .StallE_o(stE[0]), .FlushE_o(flE[0]), .StallM_o(stM[0]), .FlushM_o(flM[0]),
        .StallW_o(stW[0]), .FlushW_o(flW[0]),
        .Forward1E_o(f1[0]), .Forward2E_o(f2[0]), .StallCount_o(cnt_a));

    hazard_ctrl_seq #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(32)) u_b (
        .clk_i(clk), .CpuRst_i(rst), .ICacheMiss_i(imiss), .DCacheMiss_i(dmiss),
        .BranchE_i(br), .JalrE_i(jalr), .JalD_i(jal),
        .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
        .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw),
        .RegReadD_i(rrd), .RegReadE_i(rre), .MemToRegE_i(ld),
        .RegWriteM_i(rwm), .RegWriteW_i(rww),
        .StallF_o(stF[1]), .FlushF_o(flF[1]), .StallD_o(stD[1]), .FlushD_o(flD[1]),
        .StallE_o(stE[1]), .FlushE_o(flE[1]), .StallM_o(stM[1]), .FlushM_o(flM[1]),
        .StallW_o(stW[1]), .FlushW_o(flW[1]),
        .Forward1E_o(f1[1]), .Forward2E_o(f2[1]), .StallCount_o(cnt_b));

    // Youngest producer wins: MEM result before WB result.
    function automatic logic [1:0] fwd_model(input logic [4:0] rs, input logic used);
        if (used && rs != 0 && rdm == rs && rwm != 0) return 2'b10;
        if (used && rs != 0 && rdw == rs && rww != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit lu_model();
        return ld && rde != 0 && ((rrd[1] && rs1d == rde) || (rrd[0] && rs2d == rde));
    endfunction

    // {StallF,FlushF,StallD,FlushD,StallE,FlushE,StallM,FlushM,StallW,FlushW,F1,F2}
    function automatic logic [13:0] exp_ctl(input int k);
        bit busy, redirect;
        logic sF, sD, fD, fE;
        if (rst) return 14'b0101010101_0000;
        if (dmiss) return {10'b1010101010, fwd_model(rs1e, rre[1]), fwd_model(rs2e, rre[0])};
        busy     = (rem[k] > 0) || lu_model();
        redirect = br || jalr;
        sF = !redirect && (imiss || busy);
        sD = !redirect && busy;
        fD = redirect || (jal && !busy) || (imiss && !busy) || (pend[k] && !imiss);
        fE = redirect || busy;
        return {sF, 1'b0, sD, fD, 1'b0, fE, 4'b0000,
                fwd_model(rs1e, rre[1]), fwd_model(rs2e, rre[0])};
    endfunction

    function automatic logic [13:0] obs_ctl(input int k);
        return {stF[k], flF[k], stD[k], flD[k], stE[k], flE[k], stM[k], flM[k],
                stW[k], flW[k], f1[k], f2[k]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; pend[k] = 0; cnt[k] = 0;
        end
    endtask

    // Checks outputs mid-cycle, then advances the model and the clock.
    task automatic cyc();
        logic [13:0] e [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e[k] = exp_ctl(k);
            chk(k == 0 ? "ctl_lat3" : "ctl_lat1", {18'b0, obs_ctl(k)}, {18'b0, e[k]});
            if (stD[k] === 1'b1) std_seen[k]++;
        end
        chk("cnt_lat3", {29'b0, cnt_a}, 32'(cnt[0]));
        chk("cnt_lat1", cnt_b, 32'(cnt[1]));
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                rem[k] = 0; pend[k] = 0; cnt[k] = 0;
            end else begin
                if (e[k][13] && cnt[k] < cmax[k]) cnt[k]++;
                if (!dmiss) begin
                    if (br || jalr)        rem[k] = 0;
                    else if (rem[k] > 0)   rem[k]--;
                    else if (lu_model())   rem[k] = lat[k] - 1;
                    if ((br || jalr) && imiss) pend[k] = 1;
                    else if (!imiss)           pend[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imiss = 0; dmiss = 0; br = 0; jalr = 0; jal = 0; ld = 0;
        rs1d = 0; rs2d = 0; rs1e = 0; rs2e = 0; rde = 0; rdm = 0; rdw = 0;
        rrd = 0; rre = 0; rwm = 0; rww = 0;
    endtask

    task automatic lu_setup();
        idle();
        ld = 1; rde = 5; rs1d = 5; rs2d = 1; rrd = 2'b10;
    endtask

    initial begin
        rst = 1;
        idle();
        model_reset();
        #1;
        cyc();
        cyc();
        rst = 0;
        cyc();

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID, then EX bubbles.
        std_seen = '{0, 0};
        lu_setup();
        cyc();
        ld = 0; rde = 0;
        repeat (5) cyc();
        chk("lu_bubbles_lat3", std_seen[0], 3);
        chk("lu_bubbles_lat1", std_seen[1], 1);

        // Same, with a data-cache miss in the second cycle.
        std_seen = '{0, 0};
        lu_setup();
        cyc();
        ld = 0; rde = 0; dmiss = 1;
        cyc();
        dmiss = 0;
        repeat (5) cyc();
        chk("lu_dmiss_lat3", std_seen[0], 4);
        chk("lu_dmiss_lat1", std_seen[1], 2);

        // lw now in WB feeding the add in EX.
        idle();
        rs1e = 5; rs2e = 1; rre = 2'b11; rdw = 5; rww = 3'b001;
        #1;
        chk("fwd_wb", {30'b0, f1[1]}, 32'b01);
        cyc();

        // x0 destination and unused sources never stall; M+W hit picks MEM.
        idle();
        ld = 1; rde = 0; rs1d = 0; rrd = 2'b10;
        #1;
        chk("lu_x0", {30'b0, stD[0], stD[1]}, 32'b0);
        cyc();
        lu_setup();
        rrd = 2'b00;
        rs1e = 7; rs2e = 7; rre = 2'b11; rdm = 7; rdw = 7; rwm = 3'b100; rww = 3'b010;
        #1;
        chk("lu_unused", {30'b0, stD[0], stD[1]}, 32'b0);
        chk("fwd_mw", {28'b0, f1[0], f2[0]}, 32'b1010);
        cyc();

        // Branch during a 3-cycle I-cache miss.
        idle();
        br = 1; imiss = 1;
        #1;
        chk("br_miss_flush", {30'b0, flD[0], flE[0]}, 32'b11);
        cyc();
        br = 0;
        cyc();
        cyc();
        imiss = 0;
        #1;
        chk("br_pend_flushd", {30'b0, flD[0], flD[1]}, 32'b11);
        cyc();
        #1;
        chk("br_pend_clear", {30'b0, flD[0], flD[1]}, 32'b0);
        cyc();

        // Redirect beats load-use; FSM stays in RUN.
        lu_setup();
        br = 1;
        #1;
        chk("redir_lu", {28'b0, stF[0], stD[0], flD[0], flE[0]}, 32'b0011);
        cyc();
        idle();
        #1;
        chk("redir_lu_run", {30'b0, stD[0], flE[0]}, 32'b0);
        cyc();

        // Saturate the 3-bit counter, enter LU_WAIT, then reset asynchronously.
        idle();
        imiss = 1;
        repeat (9) cyc();
        chk("cnt_sat", {29'b0, cnt_a}, 32'd7);
        lu_setup();
        cyc();
        ld = 0; rde = 0;
        #2;
        rst = 1;
        #1;
        chk("async_cnt", {29'b0, cnt_a}, 32'd0);
        chk("async_flush", {22'b0, flF, flD, flE, flM, flW}, {22'b0, 10'h3FF});
        chk("async_stall", {30'b0, stF[0], stD[0]}, 32'b0);
        model_reset();
        cyc();
        rst = 0;
        idle();
        rs1d = 5; rrd = 2'b10;
        #1;
        chk("post_rst_run", {28'b0, stF[0], stD[0], flE[0], stD[1]}, 32'b0);
        repeat (2) cyc();

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            imiss = ($urandom_range(0, 99) < 20);
            dmiss = ($urandom_range(0, 99) < 10);
            br    = ($urandom_range(0, 99) < 10);
            jalr  = ($urandom_range(0, 99) < 4);
            jal   = ($urandom_range(0, 99) < 10);
            ld    = ($urandom_range(0, 99) < 35);
            rs1d = 5'($urandom_range(0, 3)); rs2d = 5'($urandom_range(0, 3));
            rs1e = 5'($urandom_range(0, 3)); rs2e = 5'($urandom_range(0, 3));
            rde  = 5'($urandom_range(0, 3)); rdm  = 5'($urandom_range(0, 3));
            rdw  = 5'($urandom_range(0, 3));
            rrd  = 2'($urandom_range(0, 3)); rre  = 2'($urandom_range(0, 3));
            rwm  = ($urandom_range(0, 99) < 30) ? 3'b000 : 3'($urandom_range(1, 7));
            rww  = ($urandom_range(0, 99) < 30) ? 3'b000 : 3'($urandom_range(1, 7));
            if (n == 200) begin
                rst = 1;
                model_reset();
            end else begin
                rst = 0;
            end
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_seq.md
# hazard_ctrl_seq

Parametrised, sequential hazard controller for the 5-stage RV32I pipeline, successor to the current purely combinational hazard unit. Drives stall/flush for the IF, ID, EX, MEM and WB stage registers, and forwarding selects for EX. Adds:
- a multi-cycle load-use bubble counter for slow data memories;
- cache-miss stall handling, with a latched wrong-path-fetch flush;
- source-use qualification in ID;
- a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- LOAD_LAT, 1: bubbles inserted per load-use hazard. Legal range 1..4; 1 is the classic single bubble.
- CNT_W, 32: width of StallCount.

Ports:
- clk, input, 1: core clock; all state updates on the rising edge.
- CpuRst, input, 1: asynchronous, active-high reset.
- ICacheMiss, input, 1: instruction fetch not complete this cycle.
- DCacheMiss, input, 1: data access in MEM not complete this cycle.
- BranchE, JalrE, JalD, input, 1 each: taken branch/jalr resolved in EX; jal in ID.
- Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, input, REG_AW each: register numbers.
- RegReadD, RegReadE, input, 2 each: bit1 means rs1 is used, bit0 means rs2 is used, for the ID and EX instruction respectively.
- MemToRegE, input, 1: instruction in EX is a load.
- RegWriteM, RegWriteW, input, 3 each: nonzero means the instruction writes Rd.
- StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW, output, 1 each: stage-register controls.
- Forward1E, Forward2E, output, 2 each: 00 selects the register file, 10 selects the MEM ALU result, 01 selects the WB result.
- StallCount, output, CNT_W: number of cycles in which StallF=1, saturating.

## Operation
State:
- FSM states RUN and LU_WAIT.
- Bubble counter luCnt, width clog2(LOAD_LAT+1).
- Flag redirPend.
- StallCount register.

Load-use detect:
- luHit is true when MemToRegE && RdE!=0 && ((RegReadD[1] && RdE==Rs1D) || (RegReadD[0] && RdE==Rs2D)).
- luAct is true when luHit in RUN, or whenever the FSM is in LU_WAIT.

Redirect:
- redir is true when BranchE || JalrE.
- jmpD is JalD.

Output priority, highest first:
1. CpuRst: every Flush = 1, every Stall = 0, Forward = 00.
2. DCacheMiss: all five Stall = 1 and all Flush = 0. Redirects are ignored because the branch stays held in EX and re-asserts after the miss.
3. Otherwise:
   - StallF = ICacheMiss || luAct.
   - StallD = luAct.
   - FlushD = redir || (jmpD && !luAct) || (ICacheMiss && !luAct) || (redirPend && !ICacheMiss).
   - FlushE = redir || luAct.
   - StallE, StallM, StallW and FlushF, FlushM, FlushW = 0.
   - A redirect has priority over a load-use stall: when redir=1, StallF = StallD = 0.

FSM:
- RUN to LU_WAIT: when luHit && !redir && !DCacheMiss && LOAD_LAT>1. luCnt loads LOAD_LAT-1.
- LU_WAIT: luCnt decrements on every cycle without DCacheMiss. Return to RUN on the edge where luCnt reaches 1 and decrements.
- A redirect in LU_WAIT forces RUN and clears luCnt.
- With LOAD_LAT=1, the FSM never leaves RUN.

redirPend:
- Set on redir && ICacheMiss && !DCacheMiss.
- Cleared on the first edge with !ICacheMiss; that cycle FlushD=1 discards the wrong-path instruction.
- If set and set conditions coincide, it stays 1.

Forwarding, shown for source 1; source 2 is identical using Rs2E and RegReadE[0]:
- mHit = RdM!=0 && |RegWriteM && RegReadE[1] && RdM==Rs1E.
- wHit = RdW!=0 && |RegWriteW && RegReadE[1] && RdW==Rs1E.
- Forward1E = {mHit, wHit && !mHit}. Forwarding is also 00 under DCacheMiss is not required; it stays a combinational function of the inputs (except during CpuRst).

StallCount:
- Increments when StallF=1 and CpuRst=0.
- Holds at all-ones.

## Timing
- All outputs are combinational from inputs and state, with zero latency. State updates on the rising edge of clk.
- CpuRst asynchronously sets FSM=RUN, luCnt=0, redirPend=0 and StallCount=0. Output values under reset are listed in priority 1 above.
- Reset mid-miss or mid-LU_WAIT discards all pending state; the first cycle after release is in RUN.
- Load-use inserts exactly LOAD_LAT bubbles, plus one more for each DCacheMiss cycle overlapping the wait.
- Simultaneous load-use and ICacheMiss: FlushD=0 (ID is held) and FlushE=1.

## Test plan
- LOAD_LAT=1: lw x5 in EX with add x6,x5,x1 in ID -> exactly one cycle of StallF=StallD=FlushE=1; next cycle Forward1E=01 when the lw is in WB.
- LOAD_LAT=3, same sequence -> StallD high for 3 consecutive cycles. A DCacheMiss in the 2nd cycle extends this to 4, with all Stall=1 during the miss.
- lw x0 followed by a use of x0, or a use with RegReadD=00 -> no stall. An M and W hit on the same register -> Forward=10.
- BranchE=1 while ICacheMiss=1 for 3 cycles -> FlushD=FlushE=1 in the branch cycle; redirPend=1; FlushD=1 in the first cycle after ICacheMiss falls; then redirPend=0.
- redir and luHit in the same cycle -> StallF=StallD=0, FlushD=FlushE=1, and the FSM stays in RUN.
- Assert CpuRst asynchronously mid-LU_WAIT with StallCount=7 -> StallCount=0 and all Flush=1 immediately; after release, no stall until the next hazard; the counter saturates at 2^CNT_W-1 (test with CNT_W=3).
